// File: rtl/dma_pkg.sv
// Shared types for the byte-wide block-transfer engine.
// State encoding and transfer mode constants.
package dma_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_t;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma.sv
// Block copy / fill engine driving the data-memory port.
// One byte per memory cycle; copy alternates READ and WRITE.
module mem_dma
   import dma_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic [DATA_W-1:0] fill_data,
   output logic              busy,
   output logic              done,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] access_addr,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);

   state_t            state;
   state_t            state_nxt;
   logic              mode_q;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [ADDR_W-1:0] remaining;
   logic [DATA_W-1:0] data_buf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      busy        = 1'b1;
      done        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      access_addr = '0;
      write_data  = '0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (length == '0)
                  state_nxt = DONE;
               else if (mode == MODE_FILL)
                  state_nxt = WRITE;
               else
                  state_nxt = READ;
            end
         end
         READ: begin
            mem_read    = 1'b1;
            access_addr = src_ptr;
            state_nxt   = WRITE;
         end
         WRITE: begin
            mem_write   = 1'b1;
            access_addr = dst_ptr;
            write_data  = data_buf;
            if (remaining == ADDR_W'(1))
               state_nxt = DONE;
            else if (mode_q == MODE_FILL)
               state_nxt = WRITE;
            else
               state_nxt = READ;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // Pointers wrap naturally at 2^ADDR_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= MODE_COPY;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         data_buf  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  mode_q    <= mode;
                  src_ptr   <= src_addr;
                  dst_ptr   <= dst_addr;
                  remaining <= length;
                  data_buf  <= fill_data;
               end
            end
            READ: begin
               data_buf <= read_data;
               src_ptr  <= src_ptr + ADDR_W'(1);
            end
            WRITE: begin
               dst_ptr   <= dst_ptr + ADDR_W'(1);
               remaining <= remaining - ADDR_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma against a 256x8 behavioural memory.
// Copy, fill, wrap, zero length, overlap and mid-operation reset.
module tb_mem_dma;
   import dma_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic [7:0] src_addr = '0;
   logic [7:0] dst_addr = '0;
   logic [7:0] length = '0;
   logic [7:0] fill_data = '0;
   logic       busy;
   logic       done;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] access_addr;
   logic [7:0] write_data;
   logic [7:0] read_data;

   logic [7:0] mem [256];

   int n_cmp = 0;
   int n_bad = 0;
   int done_cyc;
   int busy_cnt;
   int rd_cnt;
   int wr_cnt;
   int both_cnt;
   logic [7:0] waddr [$];

   always #5 clk = ~clk;

   mem_dma #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mode       (mode),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .fill_data  (fill_data),
      .busy       (busy),
      .done       (done),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .access_addr(access_addr),
      .write_data (write_data),
      .read_data  (read_data)
   );

   assign read_data = mem_read ? mem[access_addr] : 8'h00;

   always @(posedge clk) begin
      if (mem_write)
         mem[access_addr] <= write_data;
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered just after a rising edge; leaves just after the edge
   // that ends the DONE cycle. Cycle 1 is the first after acceptance.
   task automatic run_op(input logic m, input logic [7:0] s,
                         input logic [7:0] d, input logic [7:0] l,
                         input logic [7:0] f, input int poke);
      mode = m;
      src_addr = s;
      dst_addr = d;
      length = l;
      fill_data = f;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      mode = ~m;
      src_addr = 8'hEE;
      dst_addr = 8'hEE;
      length = 8'h77;
      fill_data = 8'h00;
      done_cyc = 0;
      busy_cnt = 0;
      rd_cnt = 0;
      wr_cnt = 0;
      both_cnt = 0;
      waddr.delete();
      for (int c = 1; c <= 600 && done_cyc == 0; c++) begin
         start = (c == poke);
         #3;
         if (busy) busy_cnt++;
         if (mem_read) rd_cnt++;
         if (mem_write) begin
            wr_cnt++;
            waddr.push_back(access_addr);
         end
         if (mem_read && mem_write) both_cnt++;
         if (done) done_cyc = c;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      if (done_cyc == 0)
         check("timeout", 32'd0, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h11;
      mem[8'h11] = 8'h22;
      mem[8'h12] = 8'h33;
      mem[8'h13] = 8'h44;
      mem[8'h43] = 8'h3C;
      mem[8'h20] = 8'h07;
      mem[8'h21] = 8'h99;
      mem[8'h22] = 8'h99;
      mem[8'h23] = 8'h99;
      mem[8'h50] = 8'h01;
      mem[8'h51] = 8'h02;
      mem[8'h52] = 8'h03;
      mem[8'h53] = 8'h04;

      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd", 32'(mem_read), 32'd0);
      check("rst_wr", 32'(mem_write), 32'd0);
      check("rst_addr", 32'(access_addr), 32'd0);
      check("rst_wdata", 32'(write_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // copy 4 bytes, with an ignored start pulsed in cycle 3
      run_op(MODE_COPY, 8'h10, 8'h80, 8'd4, 8'h00, 3);
      check("cp_done_cyc", 32'(done_cyc), 32'd9);
      check("cp_busy_cnt", 32'(busy_cnt), 32'd9);
      check("cp_rd_cnt", 32'(rd_cnt), 32'd4);
      check("cp_wr_cnt", 32'(wr_cnt), 32'd4);
      check("cp_both", 32'(both_cnt), 32'd0);
      check("cp_idle_busy", 32'(busy), 32'd0);
      check("cp_m80", 32'(mem[8'h80]), 32'h11);
      check("cp_m81", 32'(mem[8'h81]), 32'h22);
      check("cp_m82", 32'(mem[8'h82]), 32'h33);
      check("cp_m83", 32'(mem[8'h83]), 32'h44);
      check("cp_m84", 32'(mem[8'h84]), 32'h00);
      check("cp_src10", 32'(mem[8'h10]), 32'h11);
      check("cp_src13", 32'(mem[8'h13]), 32'h44);
      check("cp_mEE", 32'(mem[8'hEE]), 32'h00);
      check("cp_nwaddr", 32'(waddr.size()), 32'd4);
      if (waddr.size() == 4) begin
         check("cp_wa0", 32'(waddr[0]), 32'h80);
         check("cp_wa3", 32'(waddr[3]), 32'h83);
      end

      // fill 3 bytes
      run_op(MODE_FILL, 8'h00, 8'h40, 8'd3, 8'hA5, 0);
      check("fl_done_cyc", 32'(done_cyc), 32'd4);
      check("fl_busy_cnt", 32'(busy_cnt), 32'd4);
      check("fl_rd_cnt", 32'(rd_cnt), 32'd0);
      check("fl_wr_cnt", 32'(wr_cnt), 32'd3);
      check("fl_m40", 32'(mem[8'h40]), 32'hA5);
      check("fl_m41", 32'(mem[8'h41]), 32'hA5);
      check("fl_m42", 32'(mem[8'h42]), 32'hA5);
      check("fl_m43", 32'(mem[8'h43]), 32'h3C);

      // fill across the top of the address space
      run_op(MODE_FILL, 8'h00, 8'hFE, 8'd4, 8'h5A, 0);
      check("wr_done_cyc", 32'(done_cyc), 32'd5);
      check("wr_nwaddr", 32'(waddr.size()), 32'd4);
      if (waddr.size() == 4) begin
         check("wr_wa0", 32'(waddr[0]), 32'hFE);
         check("wr_wa1", 32'(waddr[1]), 32'hFF);
         check("wr_wa2", 32'(waddr[2]), 32'h00);
         check("wr_wa3", 32'(waddr[3]), 32'h01);
      end
      check("wr_mFE", 32'(mem[8'hFE]), 32'h5A);
      check("wr_m00", 32'(mem[8'h00]), 32'h5A);
      check("wr_m01", 32'(mem[8'h01]), 32'h5A);
      check("wr_m02", 32'(mem[8'h02]), 32'h00);

      // zero length
      run_op(MODE_COPY, 8'h10, 8'h30, 8'd0, 8'h00, 0);
      check("z_done_cyc", 32'(done_cyc), 32'd1);
      check("z_busy_cnt", 32'(busy_cnt), 32'd1);
      check("z_rd_cnt", 32'(rd_cnt), 32'd0);
      check("z_wr_cnt", 32'(wr_cnt), 32'd0);

      // overlapping ascending copy propagates the first byte
      run_op(MODE_COPY, 8'h20, 8'h21, 8'd3, 8'h00, 0);
      check("ov_done_cyc", 32'(done_cyc), 32'd7);
      check("ov_m21", 32'(mem[8'h21]), 32'h07);
      check("ov_m22", 32'(mem[8'h22]), 32'h07);
      check("ov_m23", 32'(mem[8'h23]), 32'h07);

      // reset in cycle 3 (second READ) of a 4-byte copy
      mode = MODE_COPY;
      src_addr = 8'h50;
      dst_addr = 8'h90;
      length = 8'd4;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("rs_pre_rd", 32'(mem_read), 32'd1);
      check("rs_pre_addr", 32'(access_addr), 32'h51);
      #1;
      rst_n = 1'b0;
      #1;
      check("rs_busy", 32'(busy), 32'd0);
      check("rs_done", 32'(done), 32'd0);
      check("rs_rd", 32'(mem_read), 32'd0);
      check("rs_wr", 32'(mem_write), 32'd0);
      check("rs_addr", 32'(access_addr), 32'd0);
      check("rs_wdata", 32'(write_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rs_m90", 32'(mem[8'h90]), 32'h01);
      check("rs_m91", 32'(mem[8'h91]), 32'h00);
      check("rs_idle", 32'(busy), 32'd0);

      run_op(MODE_COPY, 8'h50, 8'h90, 8'd4, 8'h00, 0);
      check("ra_done_cyc", 32'(done_cyc), 32'd9);
      check("ra_m90", 32'(mem[8'h90]), 32'h01);
      check("ra_m91", 32'(mem[8'h91]), 32'h02);
      check("ra_m92", 32'(mem[8'h92]), 32'h03);
      check("ra_m93", 32'(mem[8'h93]), 32'h04);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
